// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM states, status codes, widths.
package run_ctrl_pkg;

   localparam int unsigned CNT_W    = 32;
   localparam int unsigned RET_W    = 16;
   localparam int unsigned STATUS_W = 2;
   localparam int unsigned DRAIN_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef logic [STATUS_W-1:0] status_t;

   localparam status_t STATUS_NONE    = 2'b00;
   localparam status_t STATUS_HALTED  = 2'b01;
   localparam status_t STATUS_TIMEOUT = 2'b10;
   localparam status_t STATUS_ABORTED = 2'b11;

endpackage

// File: rtl/run_ctrl_if.sv
// Host/CPU-facing signal bundle of the run controller; master drives commands and CPU status.
interface run_ctrl_if;
   import run_ctrl_pkg::*;

   logic                start;
   logic                step_mode;
   logic                step;
   logic                abort;
   logic                is_halt;
   logic [RET_W-1:0]    ret_val;
   logic                cpu_en;
   logic                cpu_rst;
   logic                busy;
   logic                done;
   status_t             status;
   logic [RET_W-1:0]    result;
   logic [CNT_W-1:0]    cycle_count;

   modport master (
      output start, step_mode, step, abort, is_halt, ret_val,
      input  cpu_en, cpu_rst, busy, done, status, result, cycle_count
   );

   modport slave (
      input  start, step_mode, step, abort, is_halt, ret_val,
      output cpu_en, cpu_rst, busy, done, status, result, cycle_count
   );

endinterface

// File: rtl/run_cycle_counter.sv
// Enable-gated cycle counter with synchronous clear that sticks at all-ones.
module run_cycle_counter
   import run_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences a CPU through reset, free-run/single-step execution, drain and done.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned CYCLE_LIMIT  = 500000,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input logic       clk,
   input logic       rst,
   run_ctrl_if.slave bus
);

   state_e            state_q;
   state_e            state_d;
   logic [DRAIN_W-1:0] drain_q;
   logic [CNT_W-1:0]  cnt;
   logic [RET_W-1:0]  result_q;
   status_t           status_q;
   logic              done_q;
   logic              cpu_en_c;
   logic              cpu_rst_c;
   logic              busy_c;
   logic              start_c;
   logic              timeout_c;
   logic              drain_last_c;

   assign start_c      = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign timeout_c    = cpu_en_c && (cnt == CNT_W'(CYCLE_LIMIT - 1));
   assign drain_last_c = (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Abort outranks halt, which outranks timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start_c) state_d = ST_RUN;
         ST_RUN: begin
            if (bus.abort)        state_d = ST_DONE;
            else if (bus.is_halt) state_d = ST_DRAIN;
            else if (timeout_c)   state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (bus.abort)         state_d = ST_DONE;
            else if (drain_last_c) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // CPU controls decode straight from state so reset takes effect without a clock.
   always_comb begin
      cpu_en_c  = 1'b0;
      cpu_rst_c = 1'b0;
      busy_c    = 1'b0;
      case (state_q)
         ST_IDLE:  cpu_rst_c = 1'b1;
         ST_RUN: begin
            busy_c   = 1'b1;
            cpu_en_c = bus.step_mode ? bus.step : 1'b1;
         end
         ST_DRAIN: busy_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    drain_q <= '0;
      else if (state_q == ST_DRAIN) drain_q <= drain_q + DRAIN_W'(1);
      else                        drain_q <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         status_q <= STATUS_NONE;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
         if (start_c) begin
            result_q <= '0;
            status_q <= STATUS_NONE;
         end else if (state_q == ST_RUN) begin
            if (bus.abort) begin
               status_q <= STATUS_ABORTED;
            end else if (bus.is_halt) begin
               result_q <= bus.ret_val;
               status_q <= STATUS_HALTED;
            end else if (timeout_c) begin
               status_q <= STATUS_TIMEOUT;
            end
         end else if ((state_q == ST_DRAIN) && bus.abort) begin
            status_q <= STATUS_ABORTED;
         end
      end
   end

   run_cycle_counter u_cycle_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_c),
      .en    (cpu_en_c),
      .count (cnt)
   );

   assign bus.cpu_en      = cpu_en_c;
   assign bus.cpu_rst     = cpu_rst_c;
   assign bus.busy        = busy_c;
   assign bus.done        = done_q;
   assign bus.status      = status_q;
   assign bus.result      = result_q;
   assign bus.cycle_count = cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed and random runs checked against a per-run outcome model.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int unsigned LIMIT = 20;
   localparam int unsigned DRAIN = 4;
   localparam int unsigned PMAX  = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   run_ctrl_if bus ();

   run_ctrl #(.CYCLE_LIMIT(LIMIT), .DRAIN_CYCLES(DRAIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Stimulus plan for one run: one entry per cycle spent in RUN.
   logic        p_sm    [PMAX];
   logic        p_st    [PMAX];
   logic        p_halt  [PMAX];
   logic        p_abort [PMAX];
   logic [15:0] p_ret   [PMAX];
   int unsigned plen;

   int unsigned exp_end;
   int unsigned exp_count;
   logic [1:0]  exp_status;
   logic [15:0] exp_result;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_plan(input int unsigned n);
      plen = n;
      for (int i = 0; i < int'(PMAX); i++) begin
         p_sm[i] = 1'b0; p_st[i] = 1'b0; p_halt[i] = 1'b0; p_abort[i] = 1'b0; p_ret[i] = 16'h0;
      end
   endtask

   // Outcome of a run from the rules: enabled cycles accumulate until abort, halt or the limit.
   task automatic model();
      int unsigned c;
      bit en;
      c = 0;
      exp_status = STATUS_HALTED;
      exp_result = 16'h0;
      exp_end    = plen - 1;
      for (int i = 0; i < int'(plen); i++) begin
         en = !p_sm[i] || p_st[i];
         if (p_abort[i]) begin
            c += int'(en); exp_status = STATUS_ABORTED; exp_end = i; break;
         end
         if (p_halt[i]) begin
            c += int'(en); exp_status = STATUS_HALTED; exp_result = p_ret[i]; exp_end = i; break;
         end
         if (en && (c + 1 == LIMIT)) begin
            c += 1; exp_status = STATUS_TIMEOUT; exp_end = i; break;
         end
         c += int'(en);
      end
      exp_count = c;
   endtask

   task automatic drive_idle();
      bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
      bus.abort = 1'b0; bus.is_halt = 1'b0; bus.ret_val = 16'h0;
   endtask

   // Executes the current plan from IDLE or DONE and checks every observable result.
   task automatic do_run(input string tag);
      int unsigned k;
      int unsigned highs;
      model();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_clr_count"},  bus.cycle_count, 32'd0);
      chk({tag, "_clr_status"}, 32'(bus.status), 32'd0);
      chk({tag, "_clr_result"}, 32'(bus.result), 32'd0);
      for (int i = 0; i <= int'(exp_end); i++) begin
         bus.step_mode = p_sm[i]; bus.step = p_st[i]; bus.is_halt = p_halt[i];
         bus.abort = p_abort[i]; bus.ret_val = p_ret[i];
         #1;
         chk({tag, "_cpu_en"}, 32'(bus.cpu_en), 32'(!p_sm[i] || p_st[i]));
         chk({tag, "_run_busy"}, 32'({bus.busy, bus.cpu_rst}), 32'b10);
         @(posedge clk); #1;
      end
      drive_idle();
      k = 0;
      while (bus.done !== 1'b1 && k < 20) begin
         chk({tag, "_drain_io"}, 32'({bus.busy, bus.cpu_en, bus.cpu_rst}), 32'b100);
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_done_lat"}, k, (exp_status == STATUS_ABORTED) ? 32'd0 : DRAIN);
      chk({tag, "_status"}, 32'(bus.status), 32'(exp_status));
      chk({tag, "_result"}, 32'(bus.result), 32'(exp_result));
      chk({tag, "_count"},  bus.cycle_count, exp_count);
      chk({tag, "_done_io"}, 32'({bus.busy, bus.cpu_en, bus.cpu_rst}), 32'b000);
      highs = 0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         highs += int'(bus.done);
      end
      chk({tag, "_done_once"}, highs, 32'd0);
      chk({tag, "_held_count"}, bus.cycle_count, exp_count);
   endtask

   initial begin
      drive_idle();
      #1 rst = 1'b1;
      #1;
      chk("reset_io", 32'({bus.cpu_rst, bus.cpu_en, bus.busy, bus.done}), 32'b1000);
      chk("reset_status", 32'(bus.status), 32'd0);
      chk("reset_result", 32'(bus.result), 32'd0);
      chk("reset_count", bus.cycle_count, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Halt in the tenth free-running cycle.
      clear_plan(10);
      p_halt[9] = 1'b1; p_ret[9] = 16'h002A;
      do_run("halt10");
      chk("halt10_result42", 32'(bus.result), 32'd42);
      chk("halt10_count10", bus.cycle_count, 32'd10);

      // No halt: limit reached.
      clear_plan(24);
      do_run("timeout");
      chk("timeout_status", 32'(bus.status), 32'(STATUS_TIMEOUT));
      chk("timeout_count", bus.cycle_count, LIMIT);

      // Three step pulses across twelve cycles, then halt.
      clear_plan(13);
      for (int i = 0; i < 13; i++) p_sm[i] = 1'b1;
      p_st[2] = 1'b1; p_st[6] = 1'b1; p_st[10] = 1'b1;
      p_halt[12] = 1'b1; p_ret[12] = 16'hBEEF;
      do_run("step3");
      chk("step3_count", bus.cycle_count, 32'd3);

      // Abort, halt and timeout all in the same cycle.
      clear_plan(20);
      p_halt[19] = 1'b1; p_abort[19] = 1'b1; p_ret[19] = 16'h1234;
      do_run("collide");
      chk("collide_status", 32'(bus.status), 32'(STATUS_ABORTED));
      chk("collide_result", 32'(bus.result), 32'd0);

      // Second halt run started straight from DONE.
      clear_plan(7);
      p_halt[6] = 1'b1; p_ret[6] = 16'h0077;
      do_run("rerun");

      // Asynchronous reset in the middle of a run.
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_io", 32'({bus.cpu_rst, bus.busy, bus.cpu_en}), 32'b100);
      chk("midrst_count", bus.cycle_count, 32'd0);
      #3 rst = 1'b0;
      begin
         int unsigned highs;
         highs = 0;
         for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            highs += int'(bus.done);
         end
         chk("midrst_no_done", highs, 32'd0);
         chk("midrst_idle", 32'({bus.cpu_rst, bus.busy}), 32'b10);
      end

      // Random runs with per-cycle step_mode changes, sporadic halts and aborts.
      for (int r = 0; r < 40; r++) begin
         int unsigned bias;
         clear_plan($urandom_range(1, 24));
         bias = $urandom_range(0, 2);
         for (int i = 0; i < int'(plen); i++) begin
            p_sm[i]    = (bias == 0) ? 1'b0 : (bias == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            p_st[i]    = 1'($urandom_range(0, 1));
            p_halt[i]  = ($urandom_range(0, 11) == 0) || (i == int'(plen) - 1);
            p_abort[i] = ($urandom_range(0, 15) == 0);
            p_ret[i]   = 16'($urandom);
         end
         do_run("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CYCLE_LIMIT, default 500000: maximum enabled CPU cycles per run before timeout.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: idle cycles after halt/timeout before DONE; legal range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin a run; sampled in IDLE or DONE only.
REQ-006 SHALL have port step_mode  in  1  1 = CPU advances only on step pulses.
REQ-007 SHALL have port step  in  1  single-cycle advance request, used when step_mode=1.
REQ-008 SHALL have port abort  in  1  terminate the current run immediately.
REQ-009 SHALL have port is_halt  in  1  CPU halt indication.
REQ-010 SHALL have port ret_val  in  16  CPU return value, valid with is_halt.
REQ-011 SHALL have port cpu_en  out  1  pipeline advance enable.
REQ-012 SHALL have port cpu_rst  out  1  holds the CPU in reset.
REQ-013 SHALL have port busy  out  1  high in RUN or DRAIN.
REQ-014 SHALL have port done  out  1  one-cycle pulse on entry to DONE.
REQ-015 SHALL have port status  out  2  00 none, 01 halted, 10 timeout, 11 aborted.
REQ-016 SHALL have port result  out  16  captured ret_val.
REQ-017 SHALL have port cycle_count  out  32  enabled CPU cycles in the current/last run.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: cpu_rst=1 and cpu_en=0; start moves to RUN and clears cycle_count, result and status.
REQ-020 RUN: cpu_rst=0; cpu_en=1 when step_mode=0, and cpu_en=step when step_mode=1 (combinational).
REQ-021 cycle_count SHALL increment by 1 on every clock edge where cpu_en=1, saturating at 32'hFFFF_FFFF.
REQ-022 RUN with is_halt=1: result<=ret_val, status<=01, next state DRAIN; is_halt SHALL be ignored outside RUN.
REQ-023 RUN with cpu_en=1 and cycle_count==CYCLE_LIMIT-1: status<=10, next state DRAIN; cycle_count ends at CYCLE_LIMIT.
REQ-024 abort in RUN or DRAIN: status<=11, go directly to DONE; result keeps its current value.
REQ-025 Priority for simultaneous events in the same cycle SHALL be abort > halt > timeout.
REQ-026 DRAIN: cpu_en=0 and cpu_rst=0; enter DONE after exactly DRAIN_CYCLES cycles in DRAIN.
REQ-027 DONE: cpu_en=0, cpu_rst=0 (CPU state held for inspection); result, status and cycle_count held.
REQ-028 start in DONE SHALL begin a new run exactly as from IDLE; start in RUN/DRAIN SHALL be ignored.
REQ-029 done SHALL be high for exactly the one cycle following the transition into DONE.
REQ-030 step_mode changes during RUN SHALL take effect on the same cycle.

Reset
REQ-031 rst SHALL force state=IDLE, cycle_count=0, result=0, status=00, done=0, busy=0, cpu_en=0 and cpu_rst=1, regardless of clk.
REQ-032 rst asserted mid-run SHALL discard the run, with no done pulse on release.

Structure
REQ-033 Package run_ctrl_pkg SHALL hold the state enum and the STATUS_NONE/HALTED/TIMEOUT/ABORTED constants.
REQ-034 The saturating enable-gated counter SHALL be sub-module run_cycle_counter (inputs clr and en; output count).

Verification
REQ-035 Bench SHALL cover: start, is_halt with ret_val=16'h002A at cycle 10 -> status=01, result=42, cycle_count=10, done pulse 4 cycles later.
REQ-036 Bench SHALL cover: CYCLE_LIMIT=20, no halt -> status=10, cycle_count=20, done exactly once.
REQ-037 Bench SHALL cover: step_mode=1 with 3 step pulses spread over 12 cycles, then halt -> cycle_count=3.
REQ-038 Bench SHALL cover: abort, is_halt and timeout in the same cycle -> status=11, DONE next cycle, no DRAIN.
REQ-039 Bench SHALL cover: rst asserted mid-RUN without a clock edge -> cpu_rst=1 and busy=0 immediately; done never pulses.
REQ-040 Bench SHALL cover: start in DONE -> counters cleared and a second halt run completes correctly.
